// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder.
//   - RV32I load/store width codes (funct3)
//   - responder FSM state encoding
//   - funct3 legality helper (loads accept B/H/W/BU/HU, stores only B/H/W)
package dmem_responder_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    function automatic logic f3_legal(input logic is_write, input logic [2:0] f3);
        case (f3)
            F3_B, F3_H, F3_W: return 1'b1;
            F3_BU, F3_HU:     return !is_write;
            default:          return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Core <-> data-memory request/response channel.
//   req_*  : core request (valid/ready handshake)
//   rsp_*  : responder reply (valid/ready handshake)
// master = core side, slave = responder side.
interface dmem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_write, req_funct3, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_write, req_funct3, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_responder_bank.sv
// dmem_bank: DEPTH_WORDS x 32 single-port RAM.
//   clk   : clock
//   addr  : word address (shared by read and write)
//   be    : per-byte write enables
//   wdata : write data (lane-positioned)
//   re    : read enable; rdata updates on the next posedge
//   rdata : registered read data
// Contents are never reset.
module dmem_bank #(
    parameter int    DEPTH_WORDS = 4096,
    parameter string INIT_FILE   = "",
    localparam int   AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic [AW-1:0] addr,
    input  logic [3:0]    be,
    input  logic [31:0]   wdata,
    input  logic          re,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (be[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
        end
        if (re) rdata <= mem[addr];
    end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: RV32I data-memory responder backed by a dmem_bank.
//   clk    : clock, all state on posedge
//   resetn : asynchronous active-low reset
//   bus    : dmem_responder_if.slave request/response channel
// Stores commit in the accept cycle and answer one cycle later; loads read
// the bank in the accept cycle, extract/extend during READ, and answer two
// cycles after accept. Range, alignment or funct3 errors answer like stores
// with rsp_err=1 and never touch the array.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter int          DEPTH_WORDS = 4096,
    parameter string       INIT_FILE   = ""
) (
    input  logic             clk,
    input  logic             resetn,
    dmem_responder_if.slave  bus
);

    localparam int          AW      = $clog2(DEPTH_WORDS);
    // 33-bit compare so BASE + size may reach 2^32 without wrapping.
    localparam logic [32:0] BASE33  = {1'b0, BASE_ADDR};
    localparam logic [32:0] LIMIT33 = BASE33 + (33'(DEPTH_WORDS) << 2);

    state_t        state, state_nx;
    logic [2:0]    lat_funct3;
    logic [1:0]    lat_lane;
    logic [31:0]   rsp_rdata_q;
    logic          rsp_err_q;

    logic [32:0]   addr33;
    logic          in_range, misaligned, req_err, accept;
    logic [AW-1:0] word_idx;
    logic [3:0]    be;
    logic [31:0]   st_data;
    logic          re;
    logic [31:0]   rd_word, rd_shift, ld_data;

    // ---------------- request decode ----------------
    assign addr33   = {1'b0, bus.req_addr};
    assign in_range = (addr33 >= BASE33) && (addr33 < LIMIT33);
    assign word_idx = AW'((addr33 - BASE33) >> 2);
    assign accept   = bus.req_valid && (state == ST_IDLE);

    always_comb begin
        misaligned = 1'b0;
        case (bus.req_funct3)
            F3_H, F3_HU: misaligned = bus.req_addr[0];
            F3_W:        misaligned = (bus.req_addr[1:0] != 2'b00);
            default:     misaligned = 1'b0;
        endcase
    end

    assign req_err = !in_range || misaligned || !f3_legal(bus.req_write, bus.req_funct3);

    // Store data is replicated across lanes so the byte enables alone pick
    // the destination bytes.
    always_comb begin
        be      = 4'b0000;
        st_data = bus.req_wdata;
        if (accept && bus.req_write && !req_err) begin
            case (bus.req_funct3[1:0])
                2'b00: begin
                    be      = 4'b0001 << bus.req_addr[1:0];
                    st_data = {4{bus.req_wdata[7:0]}};
                end
                2'b01: begin
                    be      = 4'b0011 << bus.req_addr[1:0];
                    st_data = {2{bus.req_wdata[15:0]}};
                end
                default: be = 4'b1111;
            endcase
        end
    end

    assign re = accept && !bus.req_write && !req_err;

    dmem_bank #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .INIT_FILE   (INIT_FILE)
    ) u_bank (
        .clk   (clk),
        .addr  (word_idx),
        .be    (be),
        .wdata (st_data),
        .re    (re),
        .rdata (rd_word)
    );

    // ---------------- load extraction ----------------
    // W is always lane 0, so the shifted word doubles as the W result.
    assign rd_shift = rd_word >> {lat_lane, 3'b000};

    always_comb begin
        ld_data = rd_shift;
        case (lat_funct3)
            F3_B:    ld_data = {{24{rd_shift[7]}},  rd_shift[7:0]};
            F3_H:    ld_data = {{16{rd_shift[15]}}, rd_shift[15:0]};
            F3_BU:   ld_data = {24'h0, rd_shift[7:0]};
            F3_HU:   ld_data = {16'h0, rd_shift[15:0]};
            default: ld_data = rd_shift;
        endcase
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= ST_IDLE;
        else         state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (accept) state_nx = (bus.req_write || req_err) ? ST_RESP : ST_READ;
            ST_READ: state_nx = ST_RESP;
            ST_RESP: if (bus.rsp_ready) state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    assign bus.req_ready = (state == ST_IDLE);
    assign bus.rsp_valid = (state == ST_RESP);

    // ---------------- response registers ----------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lat_funct3  <= 3'b000;
            lat_lane    <= 2'b00;
            rsp_rdata_q <= 32'h0;
            rsp_err_q   <= 1'b0;
        end else if (accept) begin
            lat_funct3  <= bus.req_funct3;
            lat_lane    <= bus.req_addr[1:0];
            rsp_rdata_q <= 32'h0;
            rsp_err_q   <= req_err;
        end else if (state == ST_READ) begin
            rsp_rdata_q <= ld_data;
            rsp_err_q   <= 1'b0;
        end
    end

    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: the driver pushes expected replies
// from a byte-level memory model, an independent monitor pops and compares.
module tb_dmem_responder;

    localparam logic [31:0] BASE  = 32'h8000_0000;
    localparam int          DEPTH = 4096;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    dmem_responder_if bus();

    dmem_responder #(
        .BASE_ADDR   (BASE),
        .DEPTH_WORDS (DEPTH),
        .INIT_FILE   ("")
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    typedef struct {
        logic [31:0] rd;
        logic        err;
        int          lat;
        int          acc;
    } exp_t;

    exp_t              sb[$];
    byte unsigned      mem[longint];
    int                cyc = 0;
    int                n_vec = 0;
    int                n_err = 0;
    bit                hold_low = 1'b1;

    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        #1;
        bus.rsp_ready = hold_low ? 1'b0 : ($urandom_range(0, 3) != 0);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Byte-addressed reference: legality from the width code, range from
    // plain 64-bit arithmetic, data assembled byte by byte.
    function automatic void model(input logic w, input logic [2:0] f3, input logic [31:0] a,
                                  input logic [31:0] wd, output logic [31:0] rd, output logic e);
        longint off = longint'({32'h0, a}) - longint'({32'h0, BASE});
        int     n   = 0;
        bit     sgn = 1'b0;
        logic [31:0] val = 32'h0;
        case (f3)
            3'b000: begin n = 1; sgn = 1'b1; end
            3'b001: begin n = 2; sgn = 1'b1; end
            3'b010: n = 4;
            3'b100: n = 1;
            3'b101: n = 2;
            default: n = 0;
        endcase
        e = (n == 0) || (w && f3[2]) || (off < 0) || (off >= 4 * DEPTH);
        if (n != 0) e = e || ((a % n) != 0);
        rd = 32'h0;
        if (e) return;
        if (w) begin
            for (int i = 0; i < n; i++) mem[off + i] = wd[8*i +: 8];
        end else begin
            for (int i = 0; i < n; i++)
                if (mem.exists(off + i)) val = val | (32'(mem[off + i]) << (8 * i));
            if (sgn && n < 4 && val[8*n - 1]) val = val | (32'hFFFF_FFFF << (8 * n));
            rd = val;
        end
    endfunction

    task automatic drive_and_push(input logic w, input logic [2:0] f3, input logic [31:0] a,
                                  input logic [31:0] wd, input bit use_x,
                                  input logic [31:0] xrd, input logic xerr);
        logic [31:0] rd;
        logic        e;
        int          t = 0;
        exp_t        ex;
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_write  = w;
        bus.req_funct3 = f3;
        bus.req_addr   = a;
        bus.req_wdata  = wd;
        while (!bus.req_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!bus.req_ready) begin
            n_vec++;
            n_err++;
            $display("FAIL req_accept_timeout: got ready=0 expected ready=1 addr=%h", a);
            bus.req_valid = 1'b0;
            return;
        end
        model(w, f3, a, wd, rd, e);
        ex.rd  = use_x ? xrd : rd;
        ex.err = use_x ? xerr : e;
        ex.lat = (w || e) ? 1 : 2;
        ex.acc = cyc;
        sb.push_back(ex);
        @(posedge clk);
        #1;
        // Scramble the bus so a responder that fails to latch shows up.
        bus.req_valid  = 1'b0;
        bus.req_write  = 1'($urandom);
        bus.req_funct3 = 3'($urandom);
        bus.req_addr   = $urandom;
        bus.req_wdata  = $urandom;
    endtask

    task automatic issue(input logic w, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        drive_and_push(w, f3, a, wd, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic issue_x(input logic w, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] wd, input logic [31:0] xrd, input logic xerr);
        drive_and_push(w, f3, a, wd, 1'b1, xrd, xerr);
    endtask

    task automatic wait_drain();
        int t = 0;
        while (sb.size() != 0 && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (sb.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
            sb.delete();
        end
    endtask

    // ---------------- monitor ----------------
    initial begin : monitor
        bit   prev_v  = 1'b0;
        bit   prev_hs = 1'b0;
        exp_t ex;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                prev_v  = 1'b0;
                prev_hs = 1'b0;
            end else begin
                if (prev_hs) chk("idle_after_hs", {30'h0, bus.req_ready, bus.rsp_valid}, 32'h2);
                if (bus.rsp_valid) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_rsp", 32'(bus.rsp_valid), 32'h0);
                    end else begin
                        ex = sb[0];
                        if (!prev_v) chk("latency", 32'(cyc - ex.acc), 32'(ex.lat));
                        chk("req_ready_in_resp", 32'(bus.req_ready), 32'h0);
                        chk("rsp_rdata", bus.rsp_rdata, ex.rd);
                        chk("rsp_err", 32'(bus.rsp_err), 32'(ex.err));
                        if (bus.rsp_ready) void'(sb.pop_front());
                    end
                end
                prev_v  = bus.rsp_valid;
                prev_hs = bus.rsp_valid && bus.rsp_ready;
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin : stim
        logic [31:0] oor [3] = '{32'h7FFF_FFFC, 32'h8000_4000, 32'hFFFF_FFFF};
        bus.req_valid  = 1'b0;
        bus.req_write  = 1'b0;
        bus.req_funct3 = 3'b000;
        bus.req_addr   = 32'h0;
        bus.req_wdata  = 32'h0;

        repeat (3) @(negedge clk);
        chk("reset_rsp_valid", 32'(bus.rsp_valid), 32'h0);
        chk("reset_rsp_err",   32'(bus.rsp_err),   32'h0);
        chk("reset_rsp_rdata", bus.rsp_rdata,      32'h0);
        chk("reset_req_ready", 32'(bus.req_ready), 32'h1);
        resetn = 1'b1;
        @(posedge clk);
        #1;
        chk("ready_after_reset", 32'(bus.req_ready), 32'h1);
        hold_low = 1'b0;

        // Known contents for the exercised window.
        for (int w = 0; w < 16; w++) issue(1'b1, 3'b010, BASE + 32'(4 * w), 32'h0);
        issue(1'b1, 3'b010, BASE + 32'(4 * (DEPTH - 1)), 32'h0);

        issue_x(1'b1, 3'b010, 32'h8000_0010, 32'hDEAD_BEEF, 32'h0, 1'b0);
        issue_x(1'b0, 3'b010, 32'h8000_0010, 32'h0, 32'hDEAD_BEEF, 1'b0);

        issue_x(1'b1, 3'b010, 32'h8000_0010, 32'h0, 32'h0, 1'b0);
        issue_x(1'b1, 3'b000, 32'h8000_0013, 32'h0000_0080, 32'h0, 1'b0);
        issue_x(1'b0, 3'b000, 32'h8000_0013, 32'h0, 32'hFFFF_FF80, 1'b0);
        issue_x(1'b0, 3'b100, 32'h8000_0013, 32'h0, 32'h0000_0080, 1'b0);
        issue_x(1'b0, 3'b010, 32'h8000_0010, 32'h0, 32'h8000_0000, 1'b0);

        issue_x(1'b0, 3'b001, 32'h8000_0001, 32'h0, 32'h0, 1'b1);
        issue_x(1'b1, 3'b010, 32'h8000_0002, 32'h1234_5678, 32'h0, 1'b1);
        issue_x(1'b0, 3'b010, 32'h8000_0000, 32'h0, 32'h0, 1'b0);

        issue_x(1'b0, 3'b010, 32'h7FFF_FFFC, 32'h0, 32'h0, 1'b1);
        issue_x(1'b0, 3'b010, 32'h8000_4000, 32'h0, 32'h0, 1'b1);
        issue_x(1'b0, 3'b010, 32'h8000_3FFC, 32'h0, 32'h0, 1'b0);
        issue_x(1'b0, 3'b010, 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b1);
        issue_x(1'b0, 3'b011, 32'h8000_0000, 32'h0, 32'h0, 1'b1);
        issue_x(1'b1, 3'b101, 32'h8000_0000, 32'h0, 32'h0, 1'b1);
        wait_drain();

        // Response stalled: monitor re-checks data and req_ready each cycle.
        hold_low = 1'b1;
        issue_x(1'b0, 3'b000, 32'h8000_0013, 32'h0, 32'hFFFF_FF80, 1'b0);
        repeat (7) @(negedge clk);
        hold_low = 1'b0;
        wait_drain();

        for (int i = 0; i < 300; i++) begin
            int          r  = $urandom_range(0, 19);
            logic [31:0] a;
            if (r < 16)       a = BASE + 32'(4 * r) + 32'($urandom_range(0, 3));
            else if (r == 16) a = BASE + 32'(4 * (DEPTH - 1)) + 32'($urandom_range(0, 3));
            else              a = oor[r - 17];
            issue(1'($urandom), 3'($urandom_range(0, 7)), a, $urandom);
        end
        wait_drain();

        // Reset while the load is in READ: response must vanish.
        hold_low = 1'b1;
        issue(1'b0, 3'b010, BASE + 32'h20, 32'h0);
        resetn = 1'b0;
        #1;
        chk("rst_mid_read_rsp_valid", 32'(bus.rsp_valid), 32'h0);
        sb.delete();
        @(negedge clk);
        resetn = 1'b1;
        #1;
        chk("rst_release_req_ready", 32'(bus.req_ready), 32'h1);
        hold_low = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("no_rsp_after_rst", 32'(bus.rsp_valid), 32'h0);
        end

        // Stores committed before reset must still be visible.
        for (int i = 0; i < 40; i++)
            issue(1'b0, 3'($urandom_range(0, 5)), BASE + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3)), 32'h0);
        wait_drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
